// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, BIST vector layout and FSM states.
// The ALU and its self-test controller both import this package.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'h0,
        ALU_OR    = 4'h1,
        ALU_ADD   = 4'h2,
        ALU_LSL   = 4'h3,
        ALU_LSR   = 4'h4,
        ALU_SUB   = 4'h6,
        ALU_PASSB = 4'h7
    } alu_ctrl_e;

    localparam int CTRL_W     = 4;
    localparam int DATA_W     = 64;
    localparam int BIST_VEC_W = CTRL_W + DATA_W + DATA_W + 1 + DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              exp_zero;
        logic [DATA_W-1:0] exp_w;
    } bist_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    function automatic bist_vec_t mk_vec(input logic [CTRL_W-1:0] ctrl,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic              exp_zero,
                                         input logic [DATA_W-1:0] exp_w);
        bist_vec_t v;
        v.ctrl     = ctrl;
        v.a        = a;
        v.b        = b;
        v.exp_zero = exp_zero;
        v.exp_w    = exp_w;
        return v;
    endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Directed-vector ROM for the ALU self-test: index -> {ctrl, A, B, expZero, expW}.
// Shift amounts stay below 64 so the result does not depend on shifter width handling.
module alu_bist_rom
    import alu_pkg::*;
(
    input  logic [7:0] index,
    output bist_vec_t  vec
);

    // Combinational vector lookup; anything past the table reads as zero.
    always_comb begin
        case (index)
            8'd0:  vec = mk_vec(ALU_ADD,   64'h0000000000001234, 64'h00000000ABCD0000, 1'b0, 64'h00000000ABCD1234);
            8'd1:  vec = mk_vec(ALU_AND,   64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 1'b0, 64'h0F000F000F000F00);
            8'd2:  vec = mk_vec(ALU_OR,    64'h00000000F0000000, 64'h000000000000000F, 1'b0, 64'h00000000F000000F);
            8'd3:  vec = mk_vec(ALU_SUB,   64'h0000000000000100, 64'h0000000000000001, 1'b0, 64'h00000000000000FF);
            8'd4:  vec = mk_vec(ALU_LSL,   64'h0000000000000001, 64'h0000000000000004, 1'b0, 64'h0000000000000010);
            8'd5:  vec = mk_vec(ALU_LSR,   64'h8000000000000000, 64'h000000000000003F, 1'b0, 64'h0000000000000001);
            8'd6:  vec = mk_vec(ALU_PASSB, 64'h0000000000005555, 64'hDEADBEEFCAFEF00D, 1'b0, 64'hDEADBEEFCAFEF00D);
            8'd7:  vec = mk_vec(ALU_AND,   64'h8C5401B5505D55B0, 64'h000000000000000D, 1'b1, 64'h0000000000000000);
            8'd8:  vec = mk_vec(ALU_ADD,   64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b1, 64'h0000000000000000);
            8'd9:  vec = mk_vec(ALU_SUB,   64'h0000000000001234, 64'h0000000000001234, 1'b1, 64'h0000000000000000);
            8'd10: vec = mk_vec(ALU_OR,    64'h0000000000000000, 64'h0000000000000000, 1'b1, 64'h0000000000000000);
            8'd11: vec = mk_vec(ALU_LSL,   64'hFFFFFFFFFFFFFFFF, 64'h0000000000000008, 1'b0, 64'hFFFFFFFFFFFFFF00);
            8'd12: vec = mk_vec(ALU_LSR,   64'h00000000000000F0, 64'h0000000000000004, 1'b0, 64'h000000000000000F);
            8'd13: vec = mk_vec(ALU_PASSB, 64'h0000000000001234, 64'h0000000000000000, 1'b1, 64'h0000000000000000);
            8'd14: vec = mk_vec(ALU_SUB,   64'h0000000000000000, 64'h0000000000000001, 1'b0, 64'hFFFFFFFFFFFFFFFF);
            8'd15: vec = mk_vec(ALU_ADD,   64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0, 64'h8000000000000000);
            8'd16: vec = mk_vec(ALU_AND,   64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFF00000000, 1'b0, 64'hA5A5A5A500000000);
            8'd17: vec = mk_vec(ALU_OR,    64'h1111111111111111, 64'h2222222222222222, 1'b0, 64'h3333333333333333);
            8'd18: vec = mk_vec(ALU_LSL,   64'h8000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000002);
            8'd19: vec = mk_vec(ALU_LSR,   64'h0000000000000001, 64'h0000000000000001, 1'b1, 64'h0000000000000000);
            8'd20: vec = mk_vec(ALU_PASSB, 64'h000000000000FFFF, 64'h0000000000000001, 1'b0, 64'h0000000000000001);
            8'd21: vec = mk_vec(ALU_SUB,   64'h0000000000000010, 64'h0000000000000003, 1'b0, 64'h000000000000000D);
            default: vec = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// Self-test controller for the 64-bit ALU: applies ROM vectors, waits a settle time,
// compares {Zero, BusW} with the expected value and tracks pass count and first failure.
module alu_bist
    import alu_pkg::*;
#(
    parameter int NUM_VECTORS   = 22,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [63:0] BusA,
    output logic [63:0] BusB,
    output logic [3:0]  ALUCtrl,
    input  logic [63:0] BusW,
    input  logic        Zero,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [7:0]  PassCount,
    output logic        FailValid,
    output logic [7:0]  FailIndex
);

    localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]      LAST_IDX    = 8'(NUM_VECTORS - 1);
    localparam logic [7:0]      NUM_VEC8    = 8'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    bist_state_e      state_r, state_s;
    logic [7:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    bist_vec_t        vec_r, vec_s;
    bist_vec_t        rom_vec_s;
    logic [7:0]       rom_idx_s;
    logic [7:0]       pass_count_r, pass_count_s;
    logic             fail_valid_r, fail_valid_s;
    logic [7:0]       fail_index_r, fail_index_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic             match_s;

    // The ROM is read for vector 0 when a run starts and for the next vector while checking.
    assign rom_idx_s = (state_r == ST_CHECK) ? (idx_r + 8'd1) : 8'd0;

    alu_bist_rom u_rom (
        .index (rom_idx_s),
        .vec   (rom_vec_s)
    );

    // Next-state, counter and result logic.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        vec_s        = vec_r;
        pass_count_s = pass_count_r;
        fail_valid_s = fail_valid_r;
        fail_index_s = fail_index_r;
        match_s      = ({Zero, BusW} == {vec_r.exp_zero, vec_r.exp_w});

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_s      = ST_SETTLE;
                    idx_s        = 8'd0;
                    cnt_s        = SETTLE_LOAD;
                    vec_s        = rom_vec_s;
                    pass_count_s = 8'd0;
                    fail_valid_s = 1'b0;
                    fail_index_s = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_CHECK;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CHECK: begin
                if (match_s) begin
                    pass_count_s = pass_count_r + 8'd1;
                end else if (!fail_valid_r) begin
                    fail_valid_s = 1'b1;
                    fail_index_s = idx_r;
                end else begin
                    fail_valid_s = fail_valid_r;
                end
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                    idx_s   = idx_r + 8'd1;
                    cnt_s   = SETTLE_LOAD;
                    vec_s   = rom_vec_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_SETTLE) || (state_s == ST_CHECK);
        done_s = (state_s == ST_DONE);
        pass_s = done_s && (pass_count_s == NUM_VEC8);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= 8'd0;
            cnt_r        <= {CNT_W{1'b0}};
            vec_r        <= '0;
            pass_count_r <= 8'd0;
            fail_valid_r <= 1'b0;
            fail_index_r <= 8'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            vec_r        <= vec_s;
            pass_count_r <= pass_count_s;
            fail_valid_r <= fail_valid_s;
            fail_index_r <= fail_index_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
        end
    end

    assign BusA      = vec_r.a;
    assign BusB      = vec_r.b;
    assign ALUCtrl   = vec_r.ctrl;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Pass      = pass_r;
    assign PassCount = pass_count_r;
    assign FailValid = fail_valid_r;
    assign FailIndex = fail_index_r;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a behavioral ALU with switchable faults answers the
// controller, and each run's timing and results are compared with hand-derived values.
module tb_alu_bist;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;
    logic [63:0] BusW;
    logic        Zero;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [7:0]  PassCount;
    logic        FailValid;
    logic [7:0]  FailIndex;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sub_as_add = 1'b0;
    bit          zero_stuck = 1'b0;
    int          run_cycles;
    bit          overlap;
    logic [7:0]  pc_at3;

    always #5 Clk = ~Clk;

    alu_bist dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BusA      (BusA),
        .BusB      (BusB),
        .ALUCtrl   (ALUCtrl),
        .BusW      (BusW),
        .Zero      (Zero),
        .Busy      (Busy),
        .Done      (Done),
        .Pass      (Pass),
        .PassCount (PassCount),
        .FailValid (FailValid),
        .FailIndex (FailIndex)
    );

    // Behavioral ALU with optional SUB->ADD and Zero-stuck-at-0 faults.
    always_comb begin
        case (ALUCtrl)
            4'h0:    BusW = BusA & BusB;
            4'h1:    BusW = BusA | BusB;
            4'h2:    BusW = BusA + BusB;
            4'h3:    BusW = BusA << BusB;
            4'h4:    BusW = BusA >> BusB;
            4'h6:    BusW = sub_as_add ? (BusA + BusB) : (BusA - BusB);
            4'h7:    BusW = BusB;
            default: BusW = 64'd0;
        endcase
        Zero = zero_stuck ? 1'b0 : (BusW == 64'd0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Pulses Start from a negedge, checks the first SETTLE cycle, then waits for Done.
    task automatic run(input bit poke);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_eq("start_busy",     64'(Busy),      64'd1);
        check_eq("start_done",     64'(Done),      64'd0);
        check_eq("start_passcnt",  64'(PassCount), 64'd0);
        check_eq("start_failvld",  64'(FailValid), 64'd0);
        check_eq("vec0_ctrl",      64'(ALUCtrl),   64'd2);
        check_eq("vec0_busa",      BusA,           64'h1234);
        check_eq("vec0_busb",      BusB,           64'hABCD0000);
        run_cycles = 0;
        overlap    = 1'b0;
        pc_at3     = 8'hFF;
        while (!Done && run_cycles < 400) begin
            if (poke && run_cycles == 4) Start = 1'b1;
            if (poke && run_cycles == 7) Start = 1'b0;
            tick();
            run_cycles++;
            if (Busy && Done) overlap = 1'b1;
            if (run_cycles == 3) pc_at3 = PassCount;
        end
        check_eq("done_cycles",   64'(run_cycles), 64'd66);
        check_eq("busy_done_ovl", 64'(overlap),    64'd0);
        check_eq("vec0_passcnt",  64'(pc_at3),     64'd1);
        check_eq("end_busy",      64'(Busy),       64'd0);
    endtask

    task automatic check_result(input string tag, input bit exp_pass, input bit exp_fv,
                                input logic [7:0] exp_fi, input logic [7:0] exp_pc);
        check_eq({tag, "_pass"},    64'(Pass),      64'(exp_pass));
        check_eq({tag, "_failvld"}, 64'(FailValid), 64'(exp_fv));
        check_eq({tag, "_failidx"}, 64'(FailIndex), 64'(exp_fi));
        check_eq({tag, "_passcnt"}, 64'(PassCount), 64'(exp_pc));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busa"},    BusA,           64'd0);
        check_eq({tag, "_busb"},    BusB,           64'd0);
        check_eq({tag, "_ctrl"},    64'(ALUCtrl),   64'd0);
        check_eq({tag, "_busy"},    64'(Busy),      64'd0);
        check_eq({tag, "_done"},    64'(Done),      64'd0);
        check_eq({tag, "_pass"},    64'(Pass),      64'd0);
        check_eq({tag, "_passcnt"}, 64'(PassCount), 64'd0);
        check_eq({tag, "_failvld"}, 64'(FailValid), 64'd0);
        check_eq({tag, "_failidx"}, 64'(FailIndex), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        @(negedge Clk);
        repeat (3) tick();
        check_reset_state("reset");
        Reset = 1'b0;
        tick();

        // Good ALU; second run also restarts straight from DONE with Start pokes mid-run.
        run(1'b0);
        check_result("good", 1'b1, 1'b0, 8'd0, 8'd22);
        check_eq("good_done", 64'(Done), 64'd1);
        run(1'b1);
        check_result("restart", 1'b1, 1'b0, 8'd0, 8'd22);

        // SUB behaves as ADD: vectors 3, 9, 14, 21 fail.
        sub_as_add = 1'b1;
        run(1'b0);
        check_result("subadd", 1'b0, 1'b1, 8'd3, 8'd18);
        sub_as_add = 1'b0;

        // Zero stuck at 0: vectors 7, 8, 9, 10, 13, 19 fail.
        zero_stuck = 1'b1;
        run(1'b0);
        check_result("zstuck", 1'b0, 1'b1, 8'd7, 8'd16);
        zero_stuck = 1'b0;

        // Reset 20 cycles into a run, then a clean run 3 cycles later.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (19) tick();
        check_eq("midrun_busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        tick();
        check_reset_state("midreset");
        Reset = 1'b0;
        repeat (3) tick();
        run(1'b0);
        check_result("after_reset", 1'b1, 1'b0, 8'd0, 8'd22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
